// File: rtl/led_seq_pkg.sv
// Shared encodings, seeds and limits for the LED pattern sequencer.
package led_seq_pkg;

  localparam int MIN_TICK_DIV = 8;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_WALK    = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_JOHNSON = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Every seed is either all-zero or a single 1 in bit 0, so only bit 0 is returned.
  function automatic logic seed(input mode_e m);
    return (m == MODE_WALK) || (m == MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler: flags a pattern advance once the count reaches (DIV >> speed) - 1.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick_en
);

  localparam int DIV = (TICK_DIV < MIN_TICK_DIV) ? MIN_TICK_DIV : TICK_DIV;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW:0] DIV_V = (CW + 1)'(DIV);

  logic [CW:0]   span;
  logic [CW-1:0] term;
  logic [CW-1:0] cnt_q, cnt_d;

  assign span = DIV_V >> speed;
  assign term = CW'(span - (CW + 1)'(1));

  // >= rather than == so a speed decrease past the current count fires at once
  assign tick_en = enable && (cnt_q >= term);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick_en ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: run/hold/step control FSM driving a four-mode pattern engine.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int TICK_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
  output logic [N_LEDS-1:0] led,
  output logic              tick,
  output logic [1:0]        state
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d, mode_in;
  dir_e              dir_q, dir_d, adv_dir;
  logic [N_LEDS-1:0] led_q, led_d, adv_led, seed_led;
  logic              tick_q, tick_d;
  logic              step_q, step_d;
  logic              step_rise, tick_en, pre_clear, reload, advance, pre_enable;

  assign mode_in    = mode_e'(mode);
  assign seed_led   = {{(N_LEDS-1){1'b0}}, seed(mode_in)};
  assign step_rise  = step & ~step_q;
  assign step_d     = step;
  assign reload     = (state_q != ST_IDLE) && (mode_in != mode_q);
  assign advance    = ((state_q == ST_RUN) && tick_en) || ((state_q == ST_HOLD) && step_rise);
  assign pre_enable = (state_q == ST_RUN);
  assign pre_clear  = reload || ((state_q == ST_IDLE) && run);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (pre_enable),
    .clear  (pre_clear),
    .speed  (speed),
    .tick_en(tick_en)
  );

  always_comb begin
    adv_led = led_q;
    adv_dir = dir_q;
    case (mode_q)
      MODE_COUNT: adv_led = led_q + {{(N_LEDS-1){1'b0}}, 1'b1};
      MODE_WALK:  adv_led = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
      MODE_BOUNCE: begin
        // Reverse at the end bit; the reversing step already moves one position back.
        if (dir_q == DIR_LEFT) begin
          if (led_q[N_LEDS-1]) begin
            adv_dir = DIR_RIGHT;
            adv_led = led_q >> 1;
          end else begin
            adv_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            adv_dir = DIR_LEFT;
            adv_led = led_q << 1;
          end else begin
            adv_led = led_q >> 1;
          end
        end
      end
      default: adv_led = {led_q[N_LEDS-2:0], ~led_q[N_LEDS-1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mode_d = mode_in;
        if (run) begin
          state_d = ST_RUN;
          led_d   = seed_led;
          dir_d   = DIR_LEFT;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (reload) begin
          led_d  = seed_led;
          dir_d  = DIR_LEFT;
          mode_d = mode_in;
        end else if (advance) begin
          led_d  = adv_led;
          dir_d  = adv_dir;
          tick_d = 1'b1;
        end
        if ((state_q == ST_RUN) && !run) begin
          state_d = ST_HOLD;
        end else if ((state_q == ST_HOLD) && run) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      led_q   <= '0;
      tick_q  <= 1'b0;
      dir_q   <= DIR_LEFT;
      step_q  <= 1'b0;
      mode_q  <= mode_in;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  assign led   = led_q;
  assign tick  = tick_q;
  assign state = state_q;

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Parametrised LED pattern sequencer that replaces the fixed two-FSM generator/pattern pair feeding the board LEDs. It contains a programmable tick prescaler, a run/hold/single-step control FSM, and a pattern engine with four selectable modes over `N_LEDS` channels. It sits between the button/switch memory and the `LED` output of `top`.

## Interface
- `N_LEDS`, default 8: pattern width in channels; minimum 2.
- `TICK_DIV`, default 8: base prescaler period in clocks; power of two, minimum 8.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `run`  in  1  level: 1 = free-run, 0 = hold.
- `step`  in  1  single-step request; rising-edge detected internally.
- `mode`  in  2  pattern select: 0 count, 1 walk, 2 bounce, 3 johnson.
- `speed`  in  2  prescaler divide select.
- `led`  out  N_LEDS  registered pattern.
- `tick`  out  1  one-cycle pulse, high in the cycle `led` shows a new value.
- `state`  out  2  FSM state: 0 IDLE, 1 RUN, 2 HOLD.

## Operation
- Reset (`reset`=0 at an edge): `led`=0, `tick`=0, `state`=IDLE, prescaler=0, bounce dir=left, step edge register=0, registered mode=`mode`.
- Control FSM:
  - IDLE -> RUN when `run`=1. On that edge, load the mode seed and clear the prescaler.
  - RUN -> HOLD when `run`=0.
  - HOLD -> RUN when `run`=1. Pattern and prescaler resume, with no reload.
  - IDLE is only re-entered through reset.
- Prescaler: counts only in RUN. Terminal value `T = (TICK_DIV >> speed) - 1`. When the count is >= T, advance the pattern, pulse `tick` and clear the count. Using >= means a mid-count `speed` decrease yields a tick on the next cycle.
- Step: in HOLD, each rising edge of `step` advances the pattern once and pulses `tick`. `step` is ignored in IDLE and RUN.
- Mode change: when `mode` differs from the registered mode in RUN or HOLD, reload the new seed, clear the prescaler, set dir=left and update the registered mode. No `tick` is generated. A reload wins over a coincident advance.
- Seeds: count 0; walk 1; bounce 1 (dir left); johnson 0.
- Advance rules:
  - count: `led+1` modulo 2^N_LEDS.
  - walk: rotate left, MSB wraps to bit 0.
  - bounce, dir left: if `led[N-1]`=1, set dir=right and shift right; otherwise shift left.
  - bounce, dir right: if `led[0]`=1, set dir=left and shift left; otherwise shift right.
  - johnson: `{led[N-2:0], ~led[N-1]}`, period 2·N_LEDS.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Advance latency: a tick occurs T+1 cycles after RUN entry or prescaler clear. With TICK_DIV=8 and speed=3, T=0, so the pattern advances every cycle.
- Step latency: `led` and `tick` update on the edge after `step` is first sampled high. Holding `step` high gives exactly one advance.
- Reset mid-operation takes priority over everything, with effect on the same edge.
- `run` dropping in the same cycle as a terminal count: the advance occurs, then the FSM enters HOLD.

## Structure
- Package `led_seq_pkg`:
  - mode encodings and state encodings;
  - `seed(mode)` function;
  - `MIN_TICK_DIV=8` constant.
- Sub-module `tick_prescaler`: counter, `speed` shift, `enable`/`clear` inputs, `tick_en` output.
- The FSM, step edge detect and pattern engine stay in `led_pattern_seq`.

## Test plan
All scenarios use N_LEDS=4 and TICK_DIV=8.
- Reset then `run`=1, mode 0, speed 0 -> `led` 0,1,2,… with `tick` every 8 cycles; 15 wraps to 0.
- Mode 2, speed 3, run -> one value per cycle: 0001,0010,0100,1000,0100,0010,0001,0010.
- Mode 3, run -> 0000,0001,0011,0111,1111,1110,1100,1000,0000 (period 8).
- Run, then `run`=0 (HOLD), then `step` held high for 5 cycles -> exactly one advance with one `tick`; no further change until the next rising edge of `step`.
- Mode changes 1->0 in the cycle the prescaler reaches terminal -> `led`=0, `tick`=0, next tick 8 cycles later.
- Assert `reset`=0 mid-pattern in RUN -> next edge gives `led`=0, `state`=IDLE, `tick`=0. `run` held at 1 after release -> seed loaded one cycle later.
